// File: rtl/dm_arbiter_pkg.sv
// Shared types and default sizes for the data-memory arbiter and its round-robin picker.
package dm_arb_pkg;

    localparam int N_CORES_DEF = 8;
    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 16;
    localparam int IDW_DEF     = 3;
    localparam int SLICE_W     = 16;

    typedef enum logic [1:0] {
        ARB,
        ACCESS,
        RESP
    } state_t;

    // Core idx's field from a bus packed as {core N-1, ..., core 1, core 0}.
    function automatic logic [SLICE_W-1:0] pick_slice(
        input logic [N_CORES_DEF*SLICE_W-1:0] pbus,
        input logic [IDW_DEF-1:0]             idx
    );
        return pbus[int'(idx)*SLICE_W +: SLICE_W];
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side and memory-side signal bundle of the data-memory arbiter.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int IDW     = IDW_DEF
) ();

    logic [N_CORES-1:0]    core_dmr;
    logic [N_CORES-1:0]    core_dmw;
    logic [N_CORES*AW-1:0] core_ar;
    logic [N_CORES*DW-1:0] core_dr;
    logic [N_CORES-1:0]    core_finish;
    logic [N_CORES-1:0]    core_ack;
    logic [DW-1:0]         core_dm;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DW-1:0]         mem_rdata;
    logic                  all_finish;

    modport slave (
        input  core_dmr, core_dmw, core_ar, core_dr, core_finish, mem_rdata,
        output core_ack, core_dm, grant_id, busy, mem_addr, mem_wdata, mem_we, mem_re,
               all_finish
    );

    modport master (
        output core_dmr, core_dmw, core_ar, core_dr, core_finish, mem_rdata,
        input  core_ack, core_dm, grant_id, busy, mem_addr, mem_wdata, mem_we, mem_re,
               all_finish
    );

endinterface

// File: rtl/dm_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester scanning upward from pointer+1,
// wrapping modulo N_CORES, so the last-served index is always lowest priority.
module rr_picker #(
    parameter int N_CORES = 8,
    parameter int IDW     = 3
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IDW-1:0]     pointer,
    output logic               found,
    output logic [IDW-1:0]     index
);

    logic [IDW-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = pointer;
        cand  = pointer;
        for (int k = 1; k <= N_CORES; k++) begin
            cand = IDW'((int'(pointer) + k) % N_CORES);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising per-core data-memory reads/writes onto one
// single-port synchronous memory; three cycles per transaction (ARB, ACCESS, RESP).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int IDW     = IDW_DEF
) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave bus
);

    state_t             state;
    state_t             state_nx;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     pick;
    logic               found;
    logic               rd_op;
    logic [N_CORES-1:0] req;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic               sel_we;
    logic               sel_re;
    logic [DW-1:0]      dm_hold;

    assign req = bus.core_dmr | bus.core_dmw;

    rr_picker #(
        .N_CORES(N_CORES),
        .IDW    (IDW)
    ) u_picker (
        .req    (req),
        .pointer(ptr),
        .found  (found),
        .index  (pick)
    );

    // A simultaneous read and write from one core is served as a write only.
    always_comb begin
        sel_addr = pick_slice(bus.core_ar, pick);
        sel_data = pick_slice(bus.core_dr, pick);
        sel_we   = bus.core_dmw[pick];
        sel_re   = bus.core_dmr[pick] & ~bus.core_dmw[pick];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARB;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB:     if (found) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= IDW'(N_CORES - 1);
            rd_op          <= 1'b0;
            dm_hold        <= '0;
            bus.grant_id   <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_re     <= 1'b0;
            bus.core_ack   <= '0;
            bus.busy       <= 1'b0;
            bus.all_finish <= 1'b0;
        end else begin
            bus.mem_we   <= 1'b0;
            bus.mem_re   <= 1'b0;
            bus.core_ack <= '0;
            unique case (state)
                ARB: begin
                    if (found) begin
                        bus.grant_id  <= pick;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_data;
                        bus.mem_we    <= sel_we;
                        bus.mem_re    <= sel_re;
                        rd_op         <= sel_re;
                        bus.busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    bus.core_ack <= N_CORES'(1) << bus.grant_id;
                end
                RESP: begin
                    ptr      <= bus.grant_id;
                    bus.busy <= 1'b0;
                    if (rd_op) dm_hold <= bus.mem_rdata;
                end
                default: ;
            endcase
            if (&bus.core_finish) bus.all_finish <= 1'b1;
        end
    end

    // Read data arrives from the memory during RESP; forward it so it is valid with the ack.
    assign bus.core_dm = (state == RESP && rd_op) ? bus.mem_rdata : dm_hold;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized request mixes checked
// against a transaction-level round-robin model and a shadow memory.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_arbiter_if bus ();

    dm_arbiter u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]  dmr, dmw, fin;
    logic [15:0] ar [8];
    logic [15:0] dr [8];

    assign bus.core_dmr    = dmr;
    assign bus.core_dmw    = dmw;
    assign bus.core_finish = fin;

    always_comb begin
        bus.core_ar = '0;
        bus.core_dr = '0;
        for (int i = 0; i < 8; i++) begin
            bus.core_ar[i*16 +: 16] = ar[i];
            bus.core_dr[i*16 +: 16] = dr[i];
        end
    end

    // Synchronous single-port memory (256 words) with a bench-side preload port.
    logic [15:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)          mem[pre_addr] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_re)      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [15:0] ref_mem [256];
    int          mptr;
    logic [15:0] model_dm;

    int total = 0;
    int bad   = 0;

    logic [2:0]  last_gid;
    logic        last_we, last_re;
    logic [7:0]  last_ack;
    logic [15:0] last_dm;
    int          ack_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [7:0] m, input int last);
        for (int k = 1; k <= 8; k++)
            if (m[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    task automatic serve_one(output int lat);
        logic [7:0]  m;
        int          w;
        bit          wr;
        logic [15:0] a, d, exp_rd;
        lat = 0;
        m = dmr | dmw;
        w = model_pick(m, mptr);
        if (w < 0) return;
        wr = dmw[w];
        a  = ar[w];
        d  = dr[w];
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.mem_we || bus.mem_re) begin
                lat = n;
                break;
            end
        end
        check("strobe_seen", 32'(lat != 0), 32'd1);
        if (lat == 0) begin
            dmr = '0;
            dmw = '0;
            return;
        end
        last_gid = bus.grant_id;
        last_we  = bus.mem_we;
        last_re  = bus.mem_re;
        check("grant_id", 32'(bus.grant_id), 32'(w));
        check("mem_addr", 32'(bus.mem_addr), 32'(a));
        check("mem_we", 32'(bus.mem_we), 32'(wr));
        check("mem_re", 32'(bus.mem_re), 32'(!wr));
        if (wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(d));
        check("busy_access", 32'(bus.busy), 32'd1);
        check("ack_access", 32'(bus.core_ack), 32'd0);
        exp_rd = ref_mem[a[7:0]];
        if (wr) ref_mem[a[7:0]] = d;
        else    model_dm = exp_rd;
        @(negedge clk);
        last_ack = bus.core_ack;
        last_dm  = bus.core_dm;
        ack_cyc  = cyc;
        check("core_ack", 32'(bus.core_ack), 32'(8'(1) << w));
        check("strobes_resp", 32'({bus.mem_we, bus.mem_re}), 32'd0);
        check("busy_resp", 32'(bus.busy), 32'd1);
        check("core_dm", 32'(bus.core_dm), 32'(model_dm));
        dmr[w] = 1'b0;
        dmw[w] = 1'b0;
        mptr   = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dmr = '0;
        dmw = '0;
        fin = '0;
        @(negedge clk);
        check("rst_ack", 32'(bus.core_ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_we_re", 32'({bus.mem_we, bus.mem_re}), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_dm", 32'(bus.core_dm), 32'd0);
        check("rst_finish", 32'(bus.all_finish), 32'd0);
        rst      = 1'b0;
        mptr     = 7;
        model_dm = '0;
        @(negedge clk);
        check("post_rst_ack", 32'(bus.core_ack), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int prev;
        int done;
        logic [7:0] m;
        int op;

        rst      = 1'b1;
        dmr      = '0;
        dmw      = '0;
        fin      = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        prev     = 0;
        for (int i = 0; i < 8; i++) begin
            ar[i] = '0;
            dr[i] = '0;
        end
        do_reset();

        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = 8'(a);
            pre_data = (a == 'h40) ? 16'hBEEF : 16'($urandom);
            ref_mem[a] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;

        // Single read: core 3 from 0x0040
        @(negedge clk);
        ar[3]  = 16'h0040;
        dmr[3] = 1'b1;
        serve_one(lat);
        check("rd_latency", 32'(lat), 32'd1);
        check("rd_gid", 32'(last_gid), 32'd3);
        check("rd_ack", 32'(last_ack), 32'h08);
        check("rd_data", 32'(last_dm), 32'hBEEF);

        // Single write from core 5, read back by core 0
        @(negedge clk);
        ar[5]  = 16'h0010;
        dr[5]  = 16'h1234;
        dmw[5] = 1'b1;
        serve_one(lat);
        check("wr_gid", 32'(last_gid), 32'd5);
        check("wr_we", 32'(last_we), 32'd1);
        check("wr_ack", 32'(last_ack), 32'h20);
        @(negedge clk);
        ar[0]  = 16'h0010;
        dmr[0] = 1'b1;
        serve_one(lat);
        check("readback", 32'(last_dm), 32'h1234);

        // Wrap and skip: last served 6, then cores 2 and 7 together
        @(negedge clk);
        ar[6]  = 16'h0003;
        dmr[6] = 1'b1;
        serve_one(lat);
        @(negedge clk);
        ar[2]  = 16'h0004;
        ar[7]  = 16'h0005;
        dmr[2] = 1'b1;
        dmr[7] = 1'b1;
        serve_one(lat);
        check("wrap_first", 32'(last_gid), 32'd7);
        serve_one(lat);
        check("wrap_second", 32'(last_gid), 32'd2);

        // Dual request: read+write from core 1 is a write only
        @(negedge clk);
        ar[1]  = 16'h0020;
        dr[1]  = 16'hA5C3;
        dmr[1] = 1'b1;
        dmw[1] = 1'b1;
        serve_one(lat);
        check("dual_we", 32'(last_we), 32'd1);
        check("dual_re", 32'(last_re), 32'd0);

        // Reset during ACCESS of a read: abandoned, no ack, core 0 first afterwards
        @(negedge clk);
        ar[4]  = 16'h0020;
        dmr[4] = 1'b1;
        done   = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.mem_re) begin
                done = 1;
                break;
            end
        end
        check("mid_rst_access", 32'(done), 32'd1);
        do_reset();
        check("mid_rst_no_ack", 32'(bus.core_ack), 32'd0);
        ar[7]  = 16'h0020;
        ar[0]  = 16'h0010;
        dmr[7] = 1'b1;
        dmr[0] = 1'b1;
        serve_one(lat);
        check("post_rst_first", 32'(last_gid), 32'd0);
        serve_one(lat);
        check("post_rst_second", 32'(last_gid), 32'd7);

        // Contention: all 8 read continuously from reset
        do_reset();
        for (int i = 0; i < 8; i++) ar[i] = 16'($urandom_range(0, 255));
        dmr = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            serve_one(lat);
            check("rr_order", 32'(last_gid), 32'(g % 8));
            if (g > 0) check("rr_spacing", 32'(ack_cyc - prev), 32'd3);
            prev = ack_cyc;
            if (g < 8) begin
                @(negedge clk);
                @(posedge clk);
                #1;
                ar[g]  = 16'($urandom_range(0, 255));
                dmr[g] = 1'b1;
            end
        end
        for (int k = 0; k < 10; k++)
            if ((dmr | dmw) != 0) serve_one(lat);

        // Randomized request mixes
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            m = 8'($urandom_range(1, 255));
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    ar[i]  = 16'($urandom_range(0, 255));
                    dr[i]  = 16'($urandom);
                    op     = int'($urandom_range(0, 2));
                    dmr[i] = (op != 1);
                    dmw[i] = (op != 0);
                end
            end
            for (int k = 0; k < 10; k++) begin
                if ((dmr | dmw) != 0) begin
                    serve_one(lat);
                    for (int j = 0; j < 8; j++)
                        if ((dmr[j] | dmw[j]) && $urandom_range(0, 3) == 0) begin
                            ar[j] = 16'($urandom_range(0, 255));
                            dr[j] = 16'($urandom);
                        end
                end
            end
            check("rand_drained", 32'(dmr | dmw), 32'd0);
        end

        // Finish aggregation
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            fin[i] = 1'b1;
            @(negedge clk);
            check("all_finish_rise", 32'(bus.all_finish), 32'(i == 7));
        end
        fin[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("all_finish_sticky", 32'(bus.all_finish), 32'd1);
        end
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
